ram_responder: RTL and testbench
================================

# ram_responder

Responder end of the RAM port driven by the memory controller. It accepts the controller's read and write requests, applies a programmable access latency, and reports progress through the shared RAM state encoding. It returns read data and commits write data to an internal word array. It sits between the memory controller and the end of the memory hierarchy, and doubles as the bench/FPGA RAM model for all cores.

## Interface
Parameters:
- LAT, 2: number of wait cycles counted after the request is latched.
- DEPTH, 16384: number of 32-bit words in the array.
- AW, 14: word-index width; must satisfy DEPTH ≤ 2**AW.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- ramREN  in  1  read request.
- ramWEN  in  1  write request.
- ramaddr  in  32  byte address; bits [1:0] ignored; word index = ramaddr[AW+1:2].
- ramstore  in  32  write data, sampled on the ACCESS cycle.
- ramload  out  32  read data.
- ramstate  out  ramstate_t  FREE / BUSY / ACCESS / ERROR.

## Operation
Registers:
- cnt (width ≥ clog2(LAT+1))
- pend valid bit
- paddr: latched word index
- pop: latched operation, read or write

Request definition:
- req = ramREN | ramWEN.
- match = pend & (paddr == ramaddr index) & (pop == current op).

ramstate (combinational) is the first of these that applies:
- !req → FREE.
- Illegal request (see Configuration) → ERROR.
- match & cnt == 0 → ACCESS.
- Otherwise → BUSY.

Sequential updates per edge, first applicable rule:
- RST: pend = 0, cnt = 0. Array contents are not altered.
- !req or ERROR: pend = 0.
- req & !match: latch the request (pend = 1, paddr, pop) and set cnt = LAT.
- match & cnt ≠ 0: cnt decrements.
- ACCESS:
  - A write commits ramstore to mem[paddr] at this edge.
  - pend = 0, so a request still held afterwards restarts with a full latency.

ramload:
- Equals mem[paddr] while ramstate == ACCESS and pop == read.
- Otherwise 0.

Boundary conditions:
- Address or op change while BUSY aborts the pending access: there is no write and no ACCESS for the old request, and the latency restarts. This is the instruction→data preemption case in the controller.
- A request dropped mid-latency returns the block to FREE with no side effects.
- Reset during BUSY or ACCESS cancels the access, and a write on that edge is not committed.
- After reset: ramstate = FREE when no request is present, and ramload = 0.

## Timing
- Request first seen in cycle 0 (BUSY) → ACCESS in cycle LAT+1. There are LAT+1 BUSY cycles.
- LAT = 0 gives BUSY for 1 cycle, then ACCESS.
- ACCESS lasts exactly one cycle per latched request.
- Read data is valid combinationally during the ACCESS cycle only.
- Write data is committed at the edge ending the ACCESS cycle.
- Back-to-back requests to different addresses: the new request is latched in the cycle after ACCESS and sees BUSY there. Throughput is one access per LAT+2 cycles.

## Configuration
RAM_ERR_CHECK_EN:
- Defined:
  - ramREN & ramWEN together → ERROR.
  - Word index ≥ DEPTH → ERROR.
  - ERROR persists while the illegal request is held; nothing is latched or written.
- Undefined:
  - Both asserted is treated as a write.
  - The index wraps modulo DEPTH.
  - ERROR is never produced.

## Structure
- ramstate_t stays in cpu_types_pkg.
- Add RAM_LAT_DEFAULT and RAM_DEPTH_DEFAULT constants to cpu_types_pkg.
- One sub-module, ram_array: DEPTH×32 storage with one combinational read port and one synchronous write port. The FSM, counter and compare logic live in ram_responder.

## Test plan
- LAT=2, read 0x40 holding mem[16]=0xDEADBEEF → cycles 0–2 BUSY, cycle 3 ACCESS with ramload=0xDEADBEEF, then FREE after REN drops.
- LAT=2, write 0x1234_5678 to 0x80, then read 0x80 → write ACCESS at cycle 3; the following read returns 0x12345678 at its own LAT+1 offset.
- Change ramaddr from 0x100 to 0x200 at cycle 1 of a write → no write to mem[64]; ACCESS at cycle 4 for 0x200.
- Assert RST during BUSY, then during the ACCESS cycle of a write → ramstate FREE with the request removed; the target word keeps its old value.
- With RAM_ERR_CHECK_EN and DEPTH=16384: read 0x10000 → ERROR. Without the macro, the same read returns mem[0].
- LAT=0: read held for 4 cycles → BUSY, ACCESS, BUSY, ACCESS.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM port state encoding, RAM operation type and responder defaults.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } ram_op_t;

  localparam int RAM_LAT_DEFAULT   = 2;
  localparam int RAM_DEPTH_DEFAULT = 16384;

endpackage

// File: rtl/ram_array.sv
// DEPTH x 32-bit word storage: one combinational read port, one synchronous write port.
module ram_array #(
  parameter int DEPTH = 16384,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);

  logic [31:0] mem [DEPTH];

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/ram_responder.sv
// RAM port responder with programmable access latency and shared ramstate reporting.
// Optional request checking (both enables, out-of-range index) is enabled by RAM_ERR_CHECK_EN.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT   = RAM_LAT_DEFAULT,
  parameter int DEPTH = RAM_DEPTH_DEFAULT,
  parameter int AW    = 14
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output ramstate_t   ramstate
);

  localparam int CW = $clog2(LAT + 2);

  logic [CW-1:0] cnt;
  logic          pend;
  logic [AW-1:0] paddr;
  ram_op_t       pop;

  logic          req;
  logic          match;
  logic          illegal;
  ram_op_t       cur_op;
  logic [AW-1:0] idx;
  logic [31:0]   rdata;
  logic          we;
  logic          unused_addr;

  assign unused_addr = ^{ramaddr[1:0], ramaddr[31:AW+2]};

  assign req    = ramREN | ramWEN;
  assign cur_op = ramWEN ? OP_WRITE : OP_READ;
  // Wrapping keeps a non-power-of-two DEPTH from indexing past the array.
  assign idx    = AW'(32'(ramaddr[AW+1:2]) % DEPTH);

`ifdef RAM_ERR_CHECK_EN
  // Range check uses the full word index so addresses above the AW window are caught.
  assign illegal = req & ((ramREN & ramWEN) | ({2'b00, ramaddr[31:2]} >= 32'(DEPTH)));
`else
  assign illegal = 1'b0;
`endif

  assign match = pend & (paddr == idx) & (pop == cur_op);

  always_comb begin
    ramstate = FREE;
    if (!req) begin
      ramstate = FREE;
    end else if (illegal) begin
      ramstate = ERROR;
    end else if (match && cnt == '0) begin
      ramstate = ACCESS;
    end else begin
      ramstate = BUSY;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend <= 1'b0;
      cnt  <= '0;
    end else if (!req || illegal) begin
      pend <= 1'b0;
    end else if (!match) begin
      pend  <= 1'b1;
      paddr <= idx;
      pop   <= cur_op;
      cnt   <= CW'(LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      pend <= 1'b0;
    end
  end

  assign we      = !RST && (ramstate == ACCESS) && (pop == OP_WRITE);
  assign ramload = (ramstate == ACCESS && pop == OP_READ) ? rdata : 32'h0;

  ram_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (CLK),
    .raddr(paddr),
    .rdata(rdata),
    .we   (we),
    .waddr(paddr),
    .wdata(ramstore)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Directed scoreboard bench for ram_responder: LAT=2 main instance plus a LAT=0 instance.
module tb_ram_responder;
  import cpu_types_pkg::*;

  typedef struct {
    logic      sel;
    ramstate_t st;
    logic [31:0] ld;
    string     tag;
  } exp_t;

  localparam logic DA = 1'b0;
  localparam logic DB = 1'b1;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic        CLK = 1'b0;
  logic        rst_a = 1'b0, ren_a = 1'b0, wen_a = 1'b0;
  logic [31:0] addr_a = '0, store_a = '0, load_a;
  ramstate_t   state_a;
  logic        rst_b = 1'b0, ren_b = 1'b0, wen_b = 1'b0;
  logic [31:0] addr_b = '0, store_b = '0, load_b;
  ramstate_t   state_b;

  always #5 CLK = ~CLK;

  ram_responder #(.LAT(2), .DEPTH(16384), .AW(14)) dut (
    .CLK(CLK), .RST(rst_a), .ramREN(ren_a), .ramWEN(wen_a), .ramaddr(addr_a),
    .ramstore(store_a), .ramload(load_a), .ramstate(state_a)
  );

  ram_responder #(.LAT(0), .DEPTH(16), .AW(4)) dut_lat0 (
    .CLK(CLK), .RST(rst_b), .ramREN(ren_b), .ramWEN(wen_b), .ramaddr(addr_b),
    .ramstore(store_b), .ramload(load_b), .ramstate(state_b)
  );

  // Pops the oldest expectation and compares it against the selected instance.
  task automatic checkOutput();
    exp_t        e;
    ramstate_t   st;
    logic [31:0] ld;
    e  = exp_q.pop_front();
    st = e.sel ? state_b : state_a;
    ld = e.sel ? load_b : load_a;
    vectors++;
    assert (st === e.st) else begin
      miscompares++;
      $error("[TB] FAIL %s state: observed %b expected %b", e.tag, st, e.st);
    end
    vectors++;
    assert (ld === e.ld) else begin
      miscompares++;
      $error("[TB] FAIL %s ramload: observed %h expected %h", e.tag, ld, e.ld);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, sample mid-cycle, advance.
  task automatic applyStimulus(input logic sel, input logic rst, input logic ren,
                               input logic wen, input logic [31:0] addr,
                               input logic [31:0] store, input ramstate_t st,
                               input logic [31:0] ld, input string tag);
    if (sel) begin
      rst_b = rst; ren_b = ren; wen_b = wen; addr_b = addr; store_b = store;
    end else begin
      rst_a = rst; ren_a = ren; wen_a = wen; addr_a = addr; store_a = store;
    end
    exp_q.push_back('{sel, st, ld, tag});
    #2;
    checkOutput();
    @(posedge CLK);
    #1;
  endtask

  // A held request: nbusy BUSY cycles then one final cycle, followed by an idle FREE cycle.
  task automatic accessSeq(input logic sel, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] store,
                           input int nbusy, input ramstate_t fst,
                           input logic [31:0] fld, input string tag);
    for (int i = 0; i < nbusy; i++)
      applyStimulus(sel, 1'b0, ren, wen, addr, store, BUSY, 32'h0, tag);
    applyStimulus(sel, 1'b0, ren, wen, addr, store, fst, fld, tag);
    applyStimulus(sel, 1'b0, 1'b0, 1'b0, addr, 32'h0, FREE, 32'h0, {tag, "_free"});
  endtask

  initial begin
    @(posedge CLK);
    #1;
    applyStimulus(DA, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "reset_a");
    applyStimulus(DB, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "reset_b");
    applyStimulus(DA, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "idle_a");

    accessSeq(DA, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 3, ACCESS, 32'h0, "preload16");
    accessSeq(DA, 1'b1, 1'b0, 32'h40, 32'h0, 3, ACCESS, 32'hDEADBEEF, "read40");

    // Write then an immediate read of the same word: the read latches in the cycle after ACCESS.
    for (int i = 0; i < 3; i++)
      applyStimulus(DA, 1'b0, 1'b0, 1'b1, 32'h80, 32'h12345678, BUSY, 32'h0, "write80");
    applyStimulus(DA, 1'b0, 1'b0, 1'b1, 32'h80, 32'h12345678, ACCESS, 32'h0, "write80");
    accessSeq(DA, 1'b1, 1'b0, 32'h80, 32'h0, 3, ACCESS, 32'h12345678, "readback80");

    accessSeq(DA, 1'b0, 1'b1, 32'h100, 32'hAAAA5555, 3, ACCESS, 32'h0, "preload64");
    applyStimulus(DA, 1'b0, 1'b0, 1'b1, 32'h100, 32'h11111111, BUSY, 32'h0, "preempt_c0");
    accessSeq(DA, 1'b0, 1'b1, 32'h200, 32'h11111111, 3, ACCESS, 32'h0, "preempt_200");
    accessSeq(DA, 1'b1, 1'b0, 32'h100, 32'h0, 3, ACCESS, 32'hAAAA5555, "no_write64");
    accessSeq(DA, 1'b1, 1'b0, 32'h200, 32'h0, 3, ACCESS, 32'h11111111, "read200");

    applyStimulus(DA, 1'b0, 1'b0, 1'b1, 32'h80, 32'h99999999, BUSY, 32'h0, "rst_busy_c0");
    applyStimulus(DA, 1'b1, 1'b0, 1'b1, 32'h80, 32'h99999999, BUSY, 32'h0, "rst_busy_c1");
    applyStimulus(DA, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, FREE, 32'h0, "rst_busy_free");
    for (int i = 0; i < 3; i++)
      applyStimulus(DA, 1'b0, 1'b0, 1'b1, 32'h80, 32'h77777777, BUSY, 32'h0, "rst_acc_busy");
    applyStimulus(DA, 1'b1, 1'b0, 1'b1, 32'h80, 32'h77777777, ACCESS, 32'h0, "rst_acc");
    applyStimulus(DA, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, FREE, 32'h0, "rst_acc_free");
    accessSeq(DA, 1'b1, 1'b0, 32'h80, 32'h0, 3, ACCESS, 32'h12345678, "kept80");

    applyStimulus(DA, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, BUSY, 32'h0, "drop_c0");
    applyStimulus(DA, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, BUSY, 32'h0, "drop_c1");
    applyStimulus(DA, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, FREE, 32'h0, "drop_free");
    accessSeq(DA, 1'b1, 1'b0, 32'h40, 32'h0, 3, ACCESS, 32'hDEADBEEF, "drop_restart");

    accessSeq(DA, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 3, ACCESS, 32'h0, "preload0");
`ifdef RAM_ERR_CHECK_EN
    repeat (3) applyStimulus(DA, 1'b0, 1'b1, 1'b0, 32'h10000, 32'h0, ERROR, 32'h0, "oob_err");
    repeat (2) applyStimulus(DA, 1'b0, 1'b1, 1'b1, 32'h0, 32'hCAFEF00D, ERROR, 32'h0, "both_err");
    applyStimulus(DA, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "err_free");
    accessSeq(DA, 1'b1, 1'b0, 32'h0, 32'h0, 3, ACCESS, 32'h0BADF00D, "err_no_write");
`else
    accessSeq(DA, 1'b1, 1'b0, 32'h10000, 32'h0, 3, ACCESS, 32'h0BADF00D, "oob_wrap");
    accessSeq(DA, 1'b1, 1'b1, 32'h0, 32'hCAFEF00D, 3, ACCESS, 32'h0, "both_write");
    accessSeq(DA, 1'b1, 1'b0, 32'h0, 32'h0, 3, ACCESS, 32'hCAFEF00D, "both_readback");
`endif

    applyStimulus(DB, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "lat0_idle");
    accessSeq(DB, 1'b0, 1'b1, 32'hC, 32'h31415926, 1, ACCESS, 32'h0, "lat0_write");
    applyStimulus(DB, 1'b0, 1'b1, 1'b0, 32'hC, 32'h0, BUSY, 32'h0, "lat0_r0");
    applyStimulus(DB, 1'b0, 1'b1, 1'b0, 32'hC, 32'h0, ACCESS, 32'h31415926, "lat0_r1");
    applyStimulus(DB, 1'b0, 1'b1, 1'b0, 32'hC, 32'h0, BUSY, 32'h0, "lat0_r2");
    applyStimulus(DB, 1'b0, 1'b1, 1'b0, 32'hC, 32'h0, ACCESS, 32'h31415926, "lat0_r3");
    applyStimulus(DB, 1'b0, 1'b0, 1'b0, 32'hC, 32'h0, FREE, 32'h0, "lat0_free");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
